// File: rtl/cache_pkg.sv
// Shared geometry, state encoding and address-split helpers for the L1 data cache.
package cache_pkg;

   localparam int unsigned INDEX_BITS_DEF = 6;
   localparam int unsigned WORD_BITS_DEF  = 2;
   localparam int unsigned TAG_BITS       = 32 - INDEX_BITS_DEF - WORD_BITS_DEF - 2;
   localparam int unsigned LINES          = 2**INDEX_BITS_DEF;
   localparam int unsigned WORDS          = 2**WORD_BITS_DEF;

   typedef enum logic [1:0] {IDLE, REFILL, RESP, WRITE} dcache_state_e;

   typedef struct packed {
      logic [TAG_BITS-1:0]    tag;
      logic                   valid;
      logic [WORDS-1:0][31:0] word;
   } line_t;

   // Helpers take the geometry explicitly so overridden instances split addresses correctly.
   function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned ib,
                                            input int unsigned wb);
      return a >> (ib + wb + 2);
   endfunction

   function automatic logic [31:0] addr_index(input logic [31:0] a, input int unsigned ib,
                                              input int unsigned wb);
      return (a >> (wb + 2)) & ((32'd1 << ib) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_word(input logic [31:0] a, input int unsigned wb);
      return (a >> 2) & ((32'd1 << wb) - 32'd1);
   endfunction

endpackage

// File: rtl/dcache_store.sv
// Tag, valid and data flop arrays with a combinational read port, one word
// write port and a tag/valid write port; all valid bits clear on rst.
module dcache_store
   import cache_pkg::*;
#(
   parameter int unsigned IDX_W = INDEX_BITS_DEF,
   parameter int unsigned WRD_W = WORD_BITS_DEF,
   parameter int unsigned TAG_W = TAG_BITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_index_i,
   input  logic [WRD_W-1:0] rd_word_i,
   output logic [TAG_W-1:0] rd_tag_o,
   output logic             rd_valid_o,
   output logic [31:0]      rd_data_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_index_i,
   input  logic [WRD_W-1:0] wr_word_i,
   input  logic [31:0]      wr_data_i,
   input  logic             tv_en_i,
   input  logic [IDX_W-1:0] tv_index_i,
   input  logic [TAG_W-1:0] tv_tag_i
);

   localparam int unsigned N_LINES = 2**IDX_W;
   localparam int unsigned N_WORDS = 2**WRD_W;

   logic [TAG_W-1:0]   tag_q  [N_LINES];
   logic [N_LINES-1:0] valid_q;
   logic [31:0]        data_q [N_LINES][N_WORDS];

   always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else if (tv_en_i) valid_q[tv_index_i] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (tv_en_i) tag_q[tv_index_i] <= tv_tag_i;
   end

   always_ff @(posedge clk) begin
      if (wr_en_i) data_q[wr_index_i][wr_word_i] <= wr_data_i;
   end

   assign rd_tag_o   = tag_q[rd_index_i];
   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_data_o  = data_q[rd_index_i][rd_word_i];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache: FSM, refill
// beat counter, DM port mux and saturating read hit/miss counters.
module l1_dcache
   import cache_pkg::*;
#(
   parameter int unsigned INDEX_BITS = INDEX_BITS_DEF,
   parameter int unsigned WORD_BITS  = WORD_BITS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        core_req,
   input  logic        core_write,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   output logic [31:0] core_rdata,
   output logic        core_wait,
   output logic        DM_enable,
   output logic        DM_write,
   output logic [31:0] DM_address,
   output logic [31:0] DM_in,
   input  logic [31:0] DM_out,
   output logic [31:0] read_hit_cnt,
   output logic [31:0] read_miss_cnt
);

   localparam int unsigned TAG_W = 32 - INDEX_BITS - WORD_BITS - 2;
   localparam logic [WORD_BITS:0] LAST_BEAT = (WORD_BITS+1)'(2**WORD_BITS);
   localparam logic [WORD_BITS:0] ONE_BEAT  = (WORD_BITS+1)'(1);

   dcache_state_e         state_q;
   logic [WORD_BITS:0]    beat_q;
   logic [31:0]           hit_cnt_q, miss_cnt_q;

   logic [TAG_W-1:0]      lk_tag, rd_tag;
   logic [INDEX_BITS-1:0] lk_index;
   logic [WORD_BITS-1:0]  lk_word, wr_word;
   logic                  rd_valid, hit, wr_en, tv_en;
   logic [31:0]           rd_data, wr_data;

   assign lk_tag   = TAG_W'(addr_tag(core_addr, INDEX_BITS, WORD_BITS));
   assign lk_index = INDEX_BITS'(addr_index(core_addr, INDEX_BITS, WORD_BITS));
   assign lk_word  = WORD_BITS'(addr_word(core_addr, WORD_BITS));
   assign hit      = rd_valid && (rd_tag == lk_tag);

   dcache_store #(.IDX_W(INDEX_BITS), .WRD_W(WORD_BITS), .TAG_W(TAG_W)) u_store (
      .clk        (clk),
      .rst        (rst),
      .rd_index_i (lk_index),
      .rd_word_i  (lk_word),
      .rd_tag_o   (rd_tag),
      .rd_valid_o (rd_valid),
      .rd_data_o  (rd_data),
      .wr_en_i    (wr_en),
      .wr_index_i (lk_index),
      .wr_word_i  (wr_word),
      .wr_data_i  (wr_data),
      .tv_en_i    (tv_en),
      .tv_index_i (lk_index),
      .tv_tag_i   (lk_tag)
   );

   always_comb begin
      core_wait  = 1'b0;
      core_rdata = '0;
      DM_enable  = 1'b0;
      DM_write   = 1'b0;
      DM_address = '0;
      DM_in      = '0;
      wr_en      = 1'b0;
      wr_word    = lk_word;
      wr_data    = core_wdata;
      tv_en      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (core_req) begin
               if (!core_write && hit) core_rdata = rd_data;
               else                    core_wait  = 1'b1;
            end
         end
         REFILL: begin
            core_wait = 1'b1;
            if (beat_q < LAST_BEAT) begin
               DM_enable  = 1'b1;
               DM_address = {core_addr[31:WORD_BITS+2], beat_q[WORD_BITS-1:0], 2'b00};
            end
            // DM_out lags the request by one beat, so it lands in word beat-1.
            if (beat_q != '0) begin
               wr_en   = 1'b1;
               wr_word = WORD_BITS'(beat_q - ONE_BEAT);
               wr_data = DM_out;
            end
            tv_en = (beat_q == LAST_BEAT);
         end
         RESP: core_rdata = rd_data;
         WRITE: begin
            DM_enable  = 1'b1;
            DM_write   = 1'b1;
            DM_address = {core_addr[31:2], 2'b00};
            DM_in      = core_wdata;
            wr_en      = hit;
         end
      endcase
      if (rst) begin
         core_wait  = 1'b0;
         core_rdata = '0;
         DM_enable  = 1'b0;
         DM_write   = 1'b0;
         DM_address = '0;
         DM_in      = '0;
         wr_en      = 1'b0;
         tv_en      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (core_req) begin
                  if (core_write) begin
                     state_q <= WRITE;
                  end else if (hit) begin
                     if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
                  end else begin
                     if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
                     beat_q  <= '0;
                     state_q <= REFILL;
                  end
               end
            end
            REFILL: begin
               beat_q <= beat_q + ONE_BEAT;
               if (beat_q == LAST_BEAT) state_q <= RESP;
            end
            RESP:  state_q <= IDLE;
            WRITE: state_q <= IDLE;
         endcase
      end
   end

   assign read_hit_cnt  = hit_cnt_q;
   assign read_miss_cnt = miss_cnt_q;

endmodule
